// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, schedule sizing, Rcon stepping,
// FSM states and the forward S-box table used by SubWord and SubBytes.
package aes_pkg;

   localparam logic [1:0] KL_128    = 2'b00;
   localparam logic [1:0] KL_192    = 2'b01;
   localparam logic [1:0] KL_256    = 2'b10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_e;

   // Element 0 is the leftmost byte, so SBOX[x] is S(x).
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [3:0] nk_of(input logic [1:0] kl);
      case (kl)
         KL_192:  nk_of = 4'd6;
         KL_256:  nk_of = 4'd8;
         default: nk_of = 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] kl);
      case (kl)
         KL_192:  nr_of = 4'd12;
         KL_256:  nr_of = 4'd14;
         default: nr_of = 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      sbox = SBOX[b];
   endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups, one per byte.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] w_i,
   output logic [31:0] w_o
);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      assign w_o[8*g +: 8] = sbox(w_i[8*g +: 8]);
   end

endmodule

// File: rtl/aes_key_schedule_iter.sv
// Word-serial AES-128/192/256 key expansion; one schedule word per cycle,
// round keys 0..Nr streamed out over a valid/ready interface.
module aes_key_schedule_iter
   import aes_pkg::*;
#(
   parameter bit EN_192 = 1'b1,
   parameter bit EN_256 = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         start_ready,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   input  logic         abort,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         busy,
   output logic         err
);

   state_e            state_q, state_d;
   logic [1:0]        kl_q, kl_d;
   logic [0:7][31:0]  win_q, win_d;
   logic [5:0]        i_q, i_d;
   logic [2:0]        ph_q, ph_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [95:0]       acc_q, acc_d;
   logic              rk_valid_q, rk_valid_d;
   logic [127:0]      rk_data_q, rk_data_d;
   logic [3:0]        rk_idx_q, rk_idx_d;
   logic              rk_last_q, rk_last_d;
   logic              err_q, err_d;

   logic [3:0]  nk, nr, old_pos;
   logic [5:0]  last_i;
   logic [31:0] w_old, w_prev, sub_in, sub_out, w_new;
   logic        key_phase, advance, hs, kl_ok;

   // The window keeps the last Nk words right-aligned: w[i-1] in slot 7,
   // w[i-Nk] in slot 8-Nk. During key loading the key simply rotates through.
   assign nk        = nk_of(kl_q);
   assign nr        = nr_of(kl_q);
   assign last_i    = {nr, 2'b11};
   assign old_pos   = 4'd8 - nk;
   assign w_old     = win_q[old_pos[2:0]];
   assign w_prev    = win_q[7];
   assign key_phase = (i_q < {2'b00, nk});
   assign sub_in    = (ph_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
   assign advance   = !rk_valid_q || rk_ready;
   assign hs        = rk_valid_q && rk_ready;
   assign kl_ok     = (key_len == KL_128) || ((key_len == KL_192) && EN_192)
                   || ((key_len == KL_256) && EN_256);

   aes_sub_word u_sub_word (
      .w_i (sub_in),
      .w_o (sub_out)
   );

   always_comb begin
      w_new = w_old ^ w_prev;
      if (key_phase)
         w_new = w_old;
      else if (ph_q == 3'd0)
         w_new = w_old ^ sub_out ^ {rcon_q, 24'h0};
      else if ((nk == 4'd8) && (ph_q == 3'd4))
         w_new = w_old ^ sub_out;
   end

   always_comb begin
      state_d    = state_q;
      kl_d       = kl_q;
      win_d      = win_q;
      i_d        = i_q;
      ph_d       = ph_q;
      rcon_d     = rcon_q;
      acc_d      = acc_q;
      rk_valid_d = rk_valid_q;
      rk_data_d  = rk_data_q;
      rk_idx_d   = rk_idx_q;
      rk_last_d  = rk_last_q;
      err_d      = 1'b0;
      if (abort) begin
         state_d    = IDLE;
         rk_valid_d = 1'b0;
         rk_last_d  = 1'b0;
         i_d        = '0;
         ph_d       = '0;
         rcon_d     = RCON_INIT;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (kl_ok) begin
                     kl_d   = key_len;
                     i_d    = '0;
                     ph_d   = '0;
                     rcon_d = RCON_INIT;
                     case (key_len)
                        KL_192:  win_d = {64'h0, key_in[255:64]};
                        KL_256:  win_d = key_in;
                        default: win_d = {128'h0, key_in[255:128]};
                     endcase
                     state_d = GEN;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            GEN: begin
               if (hs)
                  rk_valid_d = 1'b0;
               if (advance) begin
                  win_d = {win_q[1:7], w_new};
                  acc_d = {acc_q[63:0], w_new};
                  i_d   = i_q + 6'd1;
                  ph_d  = ({1'b0, ph_q} == nk - 4'd1) ? 3'd0 : ph_q + 3'd1;
                  if (!key_phase && (ph_q == 3'd0))
                     rcon_d = xtime(rcon_q);
                  // A completed key overrides the handshake clear above.
                  if (i_q[1:0] == 2'b11) begin
                     rk_data_d  = {acc_q, w_new};
                     rk_valid_d = 1'b1;
                     rk_idx_d   = i_q[5:2];
                     rk_last_d  = (i_q == last_i);
                  end
                  if (i_q == last_i)
                     state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (hs) begin
                  rk_valid_d = 1'b0;
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         kl_q       <= KL_128;
         win_q      <= '0;
         i_q        <= '0;
         ph_q       <= '0;
         rcon_q     <= RCON_INIT;
         acc_q      <= '0;
         rk_valid_q <= 1'b0;
         rk_data_q  <= '0;
         rk_idx_q   <= '0;
         rk_last_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         kl_q       <= kl_d;
         win_q      <= win_d;
         i_q        <= i_d;
         ph_q       <= ph_d;
         rcon_q     <= rcon_d;
         acc_q      <= acc_d;
         rk_valid_q <= rk_valid_d;
         rk_data_q  <= rk_data_d;
         rk_idx_q   <= rk_idx_d;
         rk_last_q  <= rk_last_d;
         err_q      <= err_d;
      end
   end

   assign start_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign rk_valid    = rk_valid_q;
   assign rk_data     = rk_data_q;
   assign rk_idx      = rk_idx_q;
   assign rk_last     = rk_last_q;
   assign err         = err_q;

endmodule
